rob_commit: RTL and testbench

Reorder buffer with in-order dual retire that drives the architectural register file write ports of the out-of-order core. Rename/dispatch allocates one entry per cycle, up to two execution units report completion per cycle, and the block retires up to two oldest completed instructions per cycle. Each retired instruction becomes one register-file write carrying the physical destination, the result, and the original architectural register number for trace output.

---
 rtl/rob_commit_if.sv | 58 +++++
 rtl/rob_commit.sv | 172 +++++++++++++++++
 tb/tb_rob_commit.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_if.sv
// rob_commit_if: handshake bundle between dispatch/execute/regfile and rob_commit.
//
//   Allocation : alloc_valid/alloc_ready handshake, destination fields, alloc_idx (current tail)
//   Completion : two independent strobe ports (cmpl_validN, cmpl_idxN, cmpl_dataN)
//   Retire     : registered register-file write ports (write_en, write_addrN, write_dataN,
//                old_addrN, retire_cnt) and the occupancy count rob_count
//
//   master : the environment (dispatch, execution units, register file)
//   slave  : the reorder buffer
interface rob_commit_if #(
  parameter int ROB_DEPTH = 16,
  parameter int PTR_W     = 4,
  parameter int AR_SIZE   = 6
);

  logic               alloc_valid;
  logic               alloc_ready;
  logic               alloc_has_dst;
  logic [AR_SIZE-1:0] alloc_pdst;
  logic [AR_SIZE-1:0] alloc_adst;
  logic [PTR_W-1:0]   alloc_idx;

  logic               cmpl_valid1;
  logic [PTR_W-1:0]   cmpl_idx1;
  logic [31:0]        cmpl_data1;
  logic               cmpl_valid2;
  logic [PTR_W-1:0]   cmpl_idx2;
  logic [31:0]        cmpl_data2;

  logic               write_en;
  logic [AR_SIZE-1:0] write_addr1;
  logic [AR_SIZE-1:0] write_addr2;
  logic [31:0]        write_data1;
  logic [31:0]        write_data2;
  logic [AR_SIZE-1:0] old_addr1;
  logic [AR_SIZE-1:0] old_addr2;
  logic [1:0]         retire_cnt;
  logic [PTR_W:0]     rob_count;

  modport master (
    output alloc_valid, alloc_has_dst, alloc_pdst, alloc_adst,
    output cmpl_valid1, cmpl_idx1, cmpl_data1,
    output cmpl_valid2, cmpl_idx2, cmpl_data2,
    input  alloc_ready, alloc_idx,
    input  write_en, write_addr1, write_addr2, write_data1, write_data2,
    input  old_addr1, old_addr2, retire_cnt, rob_count
  );

  modport slave (
    input  alloc_valid, alloc_has_dst, alloc_pdst, alloc_adst,
    input  cmpl_valid1, cmpl_idx1, cmpl_data1,
    input  cmpl_valid2, cmpl_idx2, cmpl_data2,
    output alloc_ready, alloc_idx,
    output write_en, write_addr1, write_addr2, write_data1, write_data2,
    output old_addr1, old_addr2, retire_cnt, rob_count
  );

endinterface

// File: rtl/rob_commit.sv
// rob_commit: reorder buffer with in-order dual retire.
//
// Dispatch allocates one entry per cycle at the tail, two execution units mark
// entries done, and up to the two oldest completed entries retire per cycle as
// register-file writes. Port 1 always carries the older instruction so the
// register file (which applies port 2 last) keeps the younger value.
//
// Ports:
//   clk    in  clock, rising edge
//   rstn   in  asynchronous active-low reset; discards every entry
//   io_rob     rob_commit_if.slave (allocation, completion, retire outputs)
module rob_commit #(
  parameter int ROB_DEPTH = 16,
  parameter int PTR_W     = 4,
  parameter int AR_SIZE   = 6
) (
  input  logic         clk,
  input  logic         rstn,
  rob_commit_if.slave  io_rob
);

  localparam int                 CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(ROB_DEPTH);
  localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);

  logic [ROB_DEPTH-1:0] r_valid;
  logic [ROB_DEPTH-1:0] r_done;
  logic [ROB_DEPTH-1:0] r_has_dst;
  logic [AR_SIZE-1:0]   r_pdst [ROB_DEPTH];
  logic [AR_SIZE-1:0]   r_adst [ROB_DEPTH];
  logic [31:0]          r_data [ROB_DEPTH];

  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;

  logic                 r_write_en;
  logic [AR_SIZE-1:0]   r_write_addr1;
  logic [AR_SIZE-1:0]   r_write_addr2;
  logic [31:0]          r_write_data1;
  logic [31:0]          r_write_data2;
  logic [AR_SIZE-1:0]   r_old_addr1;
  logic [AR_SIZE-1:0]   r_old_addr2;
  logic [1:0]           r_retire_cnt;

  logic                 w_alloc_ready;
  logic                 w_alloc_fire;
  logic [PTR_W-1:0]     w_head1;
  logic                 w_r0;
  logic                 w_r1;
  logic [1:0]           w_ret_n;
  logic                 w_cmpl_ok1;
  logic                 w_cmpl_ok2;

  assign w_alloc_ready = (r_count != FULL_CNT);
  assign w_alloc_fire  = io_rob.alloc_valid & w_alloc_ready;

  assign w_head1 = r_head + PTR_ONE;
  assign w_r0    = r_valid[r_head] & r_done[r_head];
  assign w_r1    = w_r0 & r_valid[w_head1] & r_done[w_head1];
  assign w_ret_n = {1'b0, w_r0} + {1'b0, w_r1};

  // An entry being allocated this very edge counts as valid for completion,
  // so dispatch and a zero-latency unit can hit the same index together.
  assign w_cmpl_ok1 = io_rob.cmpl_valid1 &
                      (r_valid[io_rob.cmpl_idx1] | (w_alloc_fire & (io_rob.cmpl_idx1 == r_tail)));
  assign w_cmpl_ok2 = io_rob.cmpl_valid2 &
                      (r_valid[io_rob.cmpl_idx2] | (w_alloc_fire & (io_rob.cmpl_idx2 == r_tail)));

  // Entry storage. Later non-blocking writes take priority: allocation sets
  // done=0, completion then overrides it, port 1 overrides port 2 on a shared
  // index, and retire clearing comes last.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid   <= '0;
      r_done    <= '0;
      r_has_dst <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_pdst[i] <= '0;
        r_adst[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_alloc_fire) begin
        r_valid[r_tail]   <= 1'b1;
        r_done[r_tail]    <= 1'b0;
        r_has_dst[r_tail] <= io_rob.alloc_has_dst;
        r_pdst[r_tail]    <= io_rob.alloc_pdst;
        r_adst[r_tail]    <= io_rob.alloc_adst;
      end
      if (w_cmpl_ok2) begin
        r_done[io_rob.cmpl_idx2] <= 1'b1;
        r_data[io_rob.cmpl_idx2] <= io_rob.cmpl_data2;
      end
      if (w_cmpl_ok1) begin
        r_done[io_rob.cmpl_idx1] <= 1'b1;
        r_data[io_rob.cmpl_idx1] <= io_rob.cmpl_data1;
      end
      if (w_r0) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
      end
      if (w_r1) begin
        r_valid[w_head1] <= 1'b0;
        r_done[w_head1]  <= 1'b0;
      end
    end
  end

  // Pointers and occupancy; pointer arithmetic wraps naturally in PTR_W bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc_fire) begin
        r_tail <= r_tail + PTR_ONE;
      end
      r_head  <= r_head + PTR_W'(w_ret_n);
      r_count <= r_count + CNT_W'(w_alloc_fire) - CNT_W'(w_ret_n);
    end
  end

  // Registered retire ports; idle ports are forced to zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_write_en    <= 1'b0;
      r_write_addr1 <= '0;
      r_write_addr2 <= '0;
      r_write_data1 <= '0;
      r_write_data2 <= '0;
      r_old_addr1   <= '0;
      r_old_addr2   <= '0;
      r_retire_cnt  <= '0;
    end else begin
      r_write_en   <= w_r0;
      r_retire_cnt <= w_ret_n;
      if (w_r0) begin
        r_write_addr1 <= r_has_dst[r_head] ? r_pdst[r_head] : '0;
        r_write_data1 <= r_data[r_head];
        r_old_addr1   <= r_adst[r_head];
      end else begin
        r_write_addr1 <= '0;
        r_write_data1 <= '0;
        r_old_addr1   <= '0;
      end
      if (w_r1) begin
        r_write_addr2 <= r_has_dst[w_head1] ? r_pdst[w_head1] : '0;
        r_write_data2 <= r_data[w_head1];
        r_old_addr2   <= r_adst[w_head1];
      end else begin
        r_write_addr2 <= '0;
        r_write_data2 <= '0;
        r_old_addr2   <= '0;
      end
    end
  end

  assign io_rob.alloc_ready = w_alloc_ready;
  assign io_rob.alloc_idx   = r_tail;
  assign io_rob.rob_count   = r_count;
  assign io_rob.write_en    = r_write_en;
  assign io_rob.write_addr1 = r_write_addr1;
  assign io_rob.write_addr2 = r_write_addr2;
  assign io_rob.write_data1 = r_write_data1;
  assign io_rob.write_data2 = r_write_data2;
  assign io_rob.old_addr1   = r_old_addr1;
  assign io_rob.old_addr2   = r_old_addr2;
  assign io_rob.retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;

  logic clk;
  logic rstn;

  int n_total;
  int n_bad;

  typedef struct packed {
    logic [1:0]  cnt;
    logic [5:0]  a1;
    logic [31:0] d1;
    logic [5:0]  o1;
    logic [5:0]  a2;
    logic [31:0] d2;
    logic [5:0]  o2;
  } ret_t;

  ret_t exp_q[$];

  rob_commit_if #(.ROB_DEPTH(16), .PTR_W(4), .AR_SIZE(6)) rob_if ();

  rob_commit #(.ROB_DEPTH(16), .PTR_W(4), .AR_SIZE(6)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .io_rob (rob_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ret_t mk(input int cnt, input int a1, input int d1, input int o1,
                              input int a2, input int d2, input int o2);
    ret_t r;
    r.cnt = 2'(cnt);
    r.a1  = 6'(a1);
    r.d1  = 32'(d1);
    r.o1  = 6'(o1);
    r.a2  = 6'(a2);
    r.d2  = 32'(d2);
    r.o2  = 6'(o2);
    return r;
  endfunction

  // Scoreboard: every observed retire cycle is matched against the oldest
  // expected record.
  always @(negedge clk) begin
    ret_t got;
    ret_t e;
    if (rstn && rob_if.write_en) begin
      got.cnt = rob_if.retire_cnt;
      got.a1  = rob_if.write_addr1;
      got.d1  = rob_if.write_data1;
      got.o1  = rob_if.old_addr1;
      got.a2  = rob_if.write_addr2;
      got.d2  = rob_if.write_data2;
      got.o2  = rob_if.old_addr2;
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_retire got cnt=%0d a1=%0d d1=%h o1=%0d a2=%0d d2=%h o2=%0d required none",
                 got.cnt, got.a1, got.d1, got.o1, got.a2, got.d2, got.o2);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL retire_record got cnt=%0d a1=%0d d1=%h o1=%0d a2=%0d d2=%h o2=%0d required cnt=%0d a1=%0d d1=%h o1=%0d a2=%0d d2=%h o2=%0d",
                   got.cnt, got.a1, got.d1, got.o1, got.a2, got.d2, got.o2,
                   e.cnt, e.a1, e.d1, e.o1, e.a2, e.d2, e.o2);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rob_if.alloc_valid   = 1'b0;
    rob_if.alloc_has_dst = 1'b0;
    rob_if.alloc_pdst    = '0;
    rob_if.alloc_adst    = '0;
    rob_if.cmpl_valid1   = 1'b0;
    rob_if.cmpl_idx1     = '0;
    rob_if.cmpl_data1    = '0;
    rob_if.cmpl_valid2   = 1'b0;
    rob_if.cmpl_idx2     = '0;
    rob_if.cmpl_data2    = '0;
  endtask

  task automatic do_reset();
    clear_in();
    exp_q.delete();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    tick();
  endtask

  task automatic alloc(input logic has, input int pd, input int ad);
    rob_if.alloc_valid   = 1'b1;
    rob_if.alloc_has_dst = has;
    rob_if.alloc_pdst    = 6'(pd);
    rob_if.alloc_adst    = 6'(ad);
  endtask

  task automatic cmpl1(input int idx, input int data);
    rob_if.cmpl_valid1 = 1'b1;
    rob_if.cmpl_idx1   = 4'(idx);
    rob_if.cmpl_data1  = 32'(data);
  endtask

  task automatic cmpl2(input int idx, input int data);
    rob_if.cmpl_valid2 = 1'b1;
    rob_if.cmpl_idx2   = 4'(idx);
    rob_if.cmpl_data2  = 32'(data);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain pending=%0d required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    clear_in();
    rstn = 1'b0;
    #2;
    n_total++;
    if (rob_if.write_en !== 1'b0 || rob_if.retire_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_we got we=%b cnt=%0d required 0 0", rob_if.write_en, rob_if.retire_cnt);
    end
    n_total++;
    if ({rob_if.write_addr1, rob_if.write_addr2, rob_if.write_data1, rob_if.write_data2,
         rob_if.old_addr1, rob_if.old_addr2} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got a1=%0d a2=%0d d1=%h d2=%h o1=%0d o2=%0d required all 0",
               rob_if.write_addr1, rob_if.write_addr2, rob_if.write_data1, rob_if.write_data2,
               rob_if.old_addr1, rob_if.old_addr2);
    end
    n_total++;
    if (rob_if.rob_count !== 5'd0 || rob_if.alloc_ready !== 1'b1 || rob_if.alloc_idx !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_state got count=%0d ready=%b idx=%0d required 0 1 0",
               rob_if.rob_count, rob_if.alloc_ready, rob_if.alloc_idx);
    end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    n_total++;
    if (rob_if.alloc_idx !== 4'd0 || rob_if.alloc_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_idx got idx=%0d ready=%b required 0 1", rob_if.alloc_idx, rob_if.alloc_ready);
    end
    alloc(1'b1, 5, 3);
    cmpl1(0, 32'h2A);
    exp_q.push_back(mk(1, 5, 32'h2A, 3, 0, 0, 0));
    tick();
    clear_in();
    n_total++;
    if (rob_if.write_en !== 1'b0 || rob_if.rob_count !== 5'd1) begin
      n_bad++;
      $display("FAIL single_early got we=%b count=%0d required 0 1", rob_if.write_en, rob_if.rob_count);
    end
    tick();
    n_total++;
    if (rob_if.write_en !== 1'b1 || rob_if.retire_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL single_retire got we=%b cnt=%0d required 1 1", rob_if.write_en, rob_if.retire_cnt);
    end
    tick();
    n_total++;
    if (rob_if.write_en !== 1'b0 || rob_if.rob_count !== 5'd0 || rob_if.write_addr1 !== 6'd0) begin
      n_bad++;
      $display("FAIL single_after got we=%b count=%0d a1=%0d required 0 0 0",
               rob_if.write_en, rob_if.rob_count, rob_if.write_addr1);
    end
    drain("single");
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc(1'b1, 10 + i, 20 + i);
      tick();
    end
    clear_in();
    n_total++;
    if (rob_if.rob_count !== 5'd3) begin
      n_bad++;
      $display("FAIL ooo_count got %0d required 3", rob_if.rob_count);
    end
    cmpl1(2, 32'h102);
    tick();
    clear_in();
    cmpl2(1, 32'h101);
    tick();
    clear_in();
    n_total++;
    if (rob_if.write_en !== 1'b0) begin
      n_bad++;
      $display("FAIL ooo_hold got we=%b required 0", rob_if.write_en);
    end
    exp_q.push_back(mk(2, 10, 32'h100, 20, 11, 32'h101, 21));
    exp_q.push_back(mk(1, 12, 32'h102, 22, 0, 0, 0));
    cmpl1(0, 32'h100);
    tick();
    clear_in();
    n_total++;
    if (rob_if.write_en !== 1'b0) begin
      n_bad++;
      $display("FAIL ooo_latency got we=%b required 0", rob_if.write_en);
    end
    tick();
    n_total++;
    if (rob_if.write_en !== 1'b1 || rob_if.retire_cnt !== 2'd2) begin
      n_bad++;
      $display("FAIL ooo_dual got we=%b cnt=%0d required 1 2", rob_if.write_en, rob_if.retire_cnt);
    end
    tick();
    n_total++;
    if (rob_if.write_en !== 1'b1 || rob_if.retire_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL ooo_single got we=%b cnt=%0d required 1 1", rob_if.write_en, rob_if.retire_cnt);
    end
    tick();
    n_total++;
    if ({rob_if.write_en, rob_if.retire_cnt, rob_if.write_addr1, rob_if.write_data1,
         rob_if.old_addr1, rob_if.rob_count} !== '0) begin
      n_bad++;
      $display("FAIL ooo_idle got we=%b cnt=%0d a1=%0d d1=%h o1=%0d count=%0d required all 0",
               rob_if.write_en, rob_if.retire_cnt, rob_if.write_addr1, rob_if.write_data1,
               rob_if.old_addr1, rob_if.rob_count);
    end
    drain("ooo");
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc(1'b1, i + 1, i);
      tick();
    end
    clear_in();
    n_total++;
    if (rob_if.rob_count !== 5'd16 || rob_if.alloc_ready !== 1'b0 || rob_if.alloc_idx !== 4'd0) begin
      n_bad++;
      $display("FAIL full_state got count=%0d ready=%b idx=%0d required 16 0 0",
               rob_if.rob_count, rob_if.alloc_ready, rob_if.alloc_idx);
    end
    alloc(1'b1, 40, 41);
    cmpl1(0, 32'hA0);
    cmpl2(1, 32'hA1);
    exp_q.push_back(mk(2, 1, 32'hA0, 0, 2, 32'hA1, 1));
    tick();
    rob_if.cmpl_valid1 = 1'b0;
    rob_if.cmpl_valid2 = 1'b0;
    n_total++;
    if (rob_if.rob_count !== 5'd16 || rob_if.alloc_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full_blocked got count=%0d ready=%b required 16 0", rob_if.rob_count, rob_if.alloc_ready);
    end
    tick();
    n_total++;
    if (rob_if.rob_count !== 5'd14 || rob_if.alloc_ready !== 1'b1 || rob_if.alloc_idx !== 4'd0) begin
      n_bad++;
      $display("FAIL full_freed got count=%0d ready=%b idx=%0d required 14 1 0",
               rob_if.rob_count, rob_if.alloc_ready, rob_if.alloc_idx);
    end
    tick();
    clear_in();
    n_total++;
    if (rob_if.rob_count !== 5'd15 || rob_if.alloc_idx !== 4'd1) begin
      n_bad++;
      $display("FAIL full_realloc got count=%0d idx=%0d required 15 1", rob_if.rob_count, rob_if.alloc_idx);
    end
    drain("full");
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      alloc(1'b1, i + 1, i + 32);
      tick();
    end
    clear_in();
    for (int k = 0; k < 7; k++) begin
      cmpl1(2 * k, 32'h1000 + 2 * k);
      cmpl2(2 * k + 1, 32'h1000 + 2 * k + 1);
      exp_q.push_back(mk(2, 2 * k + 1, 32'h1000 + 2 * k, 2 * k + 32,
                         2 * k + 2, 32'h1000 + 2 * k + 1, 2 * k + 33));
      tick();
    end
    clear_in();
    cmpl1(14, 32'h100E);
    exp_q.push_back(mk(1, 15, 32'h100E, 46, 0, 0, 0));
    tick();
    clear_in();
    drain("wrap_fill");
    n_total++;
    if (rob_if.alloc_idx !== 4'd15 || rob_if.rob_count !== 5'd0) begin
      n_bad++;
      $display("FAIL wrap_tail got idx=%0d count=%0d required 15 0", rob_if.alloc_idx, rob_if.rob_count);
    end
    alloc(1'b1, 50, 51);
    tick();
    n_total++;
    if (rob_if.alloc_idx !== 4'd0) begin
      n_bad++;
      $display("FAIL wrap_tail_wrap got idx=%0d required 0", rob_if.alloc_idx);
    end
    alloc(1'b1, 52, 53);
    tick();
    clear_in();
    cmpl1(0, 32'hB0);
    cmpl2(15, 32'hBF);
    exp_q.push_back(mk(2, 50, 32'hBF, 51, 52, 32'hB0, 53));
    tick();
    clear_in();
    drain("wrap");
  endtask

  task automatic test_no_dst();
    do_reset();
    alloc(1'b0, 9, 7);
    cmpl1(0, 32'h55);
    exp_q.push_back(mk(1, 0, 32'h55, 7, 0, 0, 0));
    tick();
    clear_in();
    tick();
    n_total++;
    if (rob_if.write_en !== 1'b1 || rob_if.write_addr1 !== 6'd0 || rob_if.old_addr1 !== 6'd7) begin
      n_bad++;
      $display("FAIL nodst_write got we=%b a1=%0d o1=%0d required 1 0 7",
               rob_if.write_en, rob_if.write_addr1, rob_if.old_addr1);
    end
    tick();
    cmpl1(7, 32'hDEAD);
    cmpl2(3, 32'hBEEF);
    tick();
    clear_in();
    tick();
    n_total++;
    if (rob_if.write_en !== 1'b0 || rob_if.rob_count !== 5'd0) begin
      n_bad++;
      $display("FAIL invalid_cmpl got we=%b count=%0d required 0 0", rob_if.write_en, rob_if.rob_count);
    end
    drain("nodst");
  endtask

  task automatic test_conflict();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      alloc(1'b1, 30 + i, i);
      tick();
    end
    clear_in();
    cmpl1(0, 32'hC0);
    cmpl2(1, 32'hC1);
    exp_q.push_back(mk(2, 30, 32'hC0, 0, 31, 32'hC1, 1));
    tick();
    cmpl1(2, 32'hC2);
    cmpl2(3, 32'hC3);
    exp_q.push_back(mk(2, 32, 32'hC2, 2, 33, 32'hC3, 3));
    tick();
    cmpl1(4, 32'h11);
    cmpl2(4, 32'h22);
    exp_q.push_back(mk(1, 34, 32'h11, 4, 0, 0, 0));
    tick();
    clear_in();
    drain("conflict");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc(1'b1, 20 + i, 40 + i);
      tick();
    end
    clear_in();
    cmpl1(0, 32'hE0);
    cmpl2(1, 32'hE1);
    tick();
    clear_in();
    tick();
    n_total++;
    if (rob_if.write_en !== 1'b1 || rob_if.retire_cnt !== 2'd2) begin
      n_bad++;
      $display("FAIL midrst_pre got we=%b cnt=%0d required 1 2", rob_if.write_en, rob_if.retire_cnt);
    end
    rstn = 1'b0;
    #1;
    n_total++;
    if ({rob_if.write_en, rob_if.retire_cnt, rob_if.write_addr1, rob_if.write_addr2,
         rob_if.write_data1, rob_if.write_data2, rob_if.old_addr1, rob_if.old_addr2,
         rob_if.rob_count, rob_if.alloc_idx} !== '0 || rob_if.alloc_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_clear got we=%b cnt=%0d a1=%0d d1=%h count=%0d ready=%b required 0 0 0 0 0 1",
               rob_if.write_en, rob_if.retire_cnt, rob_if.write_addr1, rob_if.write_data1,
               rob_if.rob_count, rob_if.alloc_ready);
    end
    #1;
    rstn = 1'b1;
    tick();
    cmpl1(2, 32'hE2);
    tick();
    clear_in();
    tick();
    n_total++;
    if (rob_if.write_en !== 1'b0 || rob_if.rob_count !== 5'd0) begin
      n_bad++;
      $display("FAIL midrst_after got we=%b count=%0d required 0 0", rob_if.write_en, rob_if.rob_count);
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rstn    = 1'b0;
    clear_in();
    test_reset();
    test_single();
    test_out_of_order();
    test_full();
    test_wrap();
    test_no_dst();
    test_conflict();
    test_reset_mid();
    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
